// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder with an internal word RAM and error flag.
// Optional byte-enable stores: define DMEM_BYTE_ENABLE_EN.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  err;
  logic                  be_err;
  logic                  commit;
  logic                  mem_we;

  assign idx = addr_q[ADDR_WIDTH+1:2];

`ifdef DMEM_BYTE_ENABLE_EN
  assign be_err = write_q && (be_q == 4'b0000);
`else
  assign be_err = 1'b0;
`endif

  assign err = (|addr_q[1:0])
             || (|addr_q[31:ADDR_WIDTH+2])
             || be_err;

  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
  // Reset on the commit edge also suppresses the array write
  assign mem_we = commit && write_q && !err && !reset;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef DMEM_BYTE_ENABLE_EN
          be_d    = req_be;
`else
          be_d    = 4'hF;
`endif
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          valid_d = 1'b1;
          error_d = err;
          rdata_d = (err || write_q) ? 32'd0 : mem[idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'hF;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus
// backpressure, reset-abort and byte-enable sequences.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(
    .ADDR_WIDTH(8),
    .LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef DMEM_BYTE_ENABLE_EN
    .req_be(req_be),
`endif
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input int bp, output logic [31:0] rd,
                     output logic er);
    int n;
    logic [31:0] hold_rd;
    logic        hold_er;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    req_be    = 4'h0;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!resp_valid && n < 40);
    chk("latency", n, LAT);
    hold_rd = resp_rdata;
    hold_er = resp_error;
    for (int i = 0; i < bp; i++) begin
      if (i == 1) req_valid = 1'b1;
      if (i == 3) req_valid = 1'b0;
      @(posedge clock);
      #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, hold_rd);
      chk("bp_error", 32'(resp_error), 32'(hold_er));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    rd = resp_rdata;
    er = resp_error;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_error", 32'(resp_error), 32'd0);
    chk("post_rdata_hold", resp_rdata, rd);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          n;

  initial begin
    vecs[0] = '{1'b1, 32'h10,       32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h10,       32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h13,       32'h1111_1111, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h10,       32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h400,      32'h0,         32'h0,         1'b1};
    vecs[5] = '{1'b1, 32'h3FC,      32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[6] = '{1'b0, 32'h3FC,      32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[7] = '{1'b1, 32'h20,       32'h0BAD_F00D, 32'h0,         1'b0};
    vecs[8] = '{1'b0, 32'h8000_0020, 32'h0,        32'h0,         1'b1};
    vecs[9] = '{1'b0, 32'h22,       32'h0,         32'h0,         1'b1};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'hF;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_error", 32'(resp_error), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);

    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    chk("idle_rr_valid", 32'(resp_valid), 32'd0);
    chk("idle_rr_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].w, vecs[i].a, vecs[i].d, 4'hF, 0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_er));
    end

    // Backpressure with a stray req_valid pulse inside the window
    txn(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er);
    chk("bp_load_rdata", rd, 32'hDEAD_BEEF);
    chk("bp_load_error", 32'(er), 32'd0);
    @(posedge clock);
    #1;
    chk("bp_no_accept", 32'(req_ready), 32'd1);
    chk("bp_no_resp", 32'(resp_valid), 32'd0);

    // Reset one edge after a store is accepted
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk("abort_in_wait", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    repeat (LAT + 2) @(posedge clock);
    #1;
    chk("abort_quiet", 32'(resp_valid), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    chk("abort_load", rd, 32'h0BAD_F00D);
    chk("abort_load_err", 32'(er), 32'd0);

`ifdef DMEM_BYTE_ENABLE_EN
    txn(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
    chk("be_store_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er);
    chk("be_load", rd, 32'hDEBB_BEDD);
    txn(1'b1, 32'h10, 32'h0, 4'b0000, 0, rd, er);
    chk("be_zero_err", 32'(er), 32'd1);
    chk("be_zero_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd, er);
    chk("be_zero_nowrite", rd, 32'hDEBB_BEDD);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
